// File: rtl/video_timing_detect.sv
// Measures incoming raster timing (line/frame periods, active extents, pixel position)
// and tracks whether the timing is stable enough to be declared locked.
`timescale 1ns/1ps
module video_timing_detect #(
    parameter int LOCK_FRAMES = 2,
    parameter int TIMEOUT     = 2048
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ce_pix,
    input  logic        hblank,
    input  logic        hsync,
    input  logic        vblank,
    input  logic        vsync,
    input  logic [7:0]  video,
    output logic [9:0]  x,
    output logic [9:0]  y,
    output logic [9:0]  h_total,
    output logic [9:0]  v_total,
    output logic [9:0]  h_active,
    output logic [9:0]  v_active,
    output logic        pixel_valid,
    output logic        frame_start,
    output logic        locked,
    output logic        pal_detect,
    output logic [15:0] frame_sum
);
    localparam int              TO_W   = $clog2(TIMEOUT + 1);
    localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT);
    localparam logic [2:0]      LOCK_N = 3'(LOCK_FRAMES);

    typedef enum logic [1:0] {S_UNLOCK, S_ACQUIRE, S_LOCK} state_t;

    function automatic logic [9:0] sat_inc(input logic [9:0] v);
        return (v == 10'd1023) ? v : v + 10'd1;
    endfunction

    function automatic logic is_pal(input logic [9:0] v);
        return ((v >= 10'd300) && (v <= 10'd320)) || ((v >= 10'd600) && (v <= 10'd640));
    endfunction

    logic            hsync_p1, hblank_p1, vsync_p1, vblank_p1;
    logic            hs_rise, vs_rise, hb_rise, hb_fall, vb_rise, vb_fall, active;
    logic [9:0]      h_cnt, ha_cnt, v_cnt;
    logic            h_seen;
    logic [15:0]     acc;
    logic [9:0]      h_new, v_new, prev_h, prev_v;
    logic [TO_W-1:0] to_cnt, to_next;
    logic            timeout, same;
    state_t          state, state_next;
    logic [2:0]      match, match_next, match_inc;

    // Stage p0: edges of the current sample against the previous ce sample
    assign hs_rise = hsync & ~hsync_p1;
    assign vs_rise = vsync & ~vsync_p1;
    assign hb_rise = hblank & ~hblank_p1;
    assign hb_fall = ~hblank & hblank_p1;
    assign vb_rise = vblank & ~vblank_p1;
    assign vb_fall = ~vblank & vblank_p1;
    assign active  = ~hblank & ~vblank;

    // First hsync edge after reset only starts the period count; it has no valid prior line.
    assign h_new   = (hs_rise && h_seen) ? h_cnt : h_total;
    assign v_new   = hs_rise ? sat_inc(v_cnt) : v_cnt;
    assign same    = (h_new == prev_h) && (v_new == prev_v);
    assign to_next = hs_rise ? '0 : ((to_cnt == TO_MAX) ? to_cnt : to_cnt + TO_W'(1));
    assign timeout = (to_next == TO_MAX);

    // Stage p1: measurement registers
    always_ff @(posedge clk) begin
        if (reset) begin
            hsync_p1    <= 1'b0;
            hblank_p1   <= 1'b0;
            vsync_p1    <= 1'b0;
            vblank_p1   <= 1'b0;
            h_cnt       <= '0;
            ha_cnt      <= '0;
            v_cnt       <= '0;
            h_seen      <= 1'b0;
            to_cnt      <= '0;
            acc         <= '0;
            prev_h      <= '0;
            prev_v      <= '0;
            x           <= '0;
            y           <= '0;
            h_total     <= '0;
            v_total     <= '0;
            h_active    <= '0;
            v_active    <= '0;
            pixel_valid <= 1'b0;
            frame_start <= 1'b0;
            pal_detect  <= 1'b0;
            frame_sum   <= '0;
        end else begin
            frame_start <= 1'b0;
            if (ce_pix) begin
                hsync_p1    <= hsync;
                hblank_p1   <= hblank;
                vsync_p1    <= vsync;
                vblank_p1   <= vblank;
                frame_start <= vs_rise;
                pixel_valid <= active;
                to_cnt      <= to_next;

                if (hs_rise) begin
                    h_cnt   <= 10'd1;
                    h_seen  <= 1'b1;
                    h_total <= h_new;
                end else begin
                    h_cnt   <= sat_inc(h_cnt);
                end

                if (hb_fall) begin
                    x      <= '0;
                    ha_cnt <= 10'd1;
                end else if (!hblank) begin
                    x      <= sat_inc(x);
                    ha_cnt <= sat_inc(ha_cnt);
                end
                if (hb_rise)
                    h_active <= ha_cnt;

                // A coincident hsync edge is already folded into v_new before the restart.
                if (vs_rise) begin
                    v_total    <= v_new;
                    v_cnt      <= '0;
                    pal_detect <= is_pal(v_new);
                    prev_h     <= h_new;
                    prev_v     <= v_new;
                end else begin
                    v_cnt      <= v_new;
                end

                if (vb_fall)
                    y <= '0;
                else if (hb_rise && !vblank)
                    y <= sat_inc(y);
                if (vb_rise)
                    v_active <= y;

                if (vb_rise) begin
                    frame_sum <= acc;
                    acc       <= '0;
                end else if (active) begin
                    acc       <= acc + {8'd0, video};
                end
            end
        end
    end

    // Stage p1: lock state machine
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_UNLOCK;
            match <= '0;
        end else if (ce_pix) begin
            state <= state_next;
            match <= match_next;
        end
    end

    assign match_inc = match + 3'd1;

    always_comb begin
        state_next = state;
        match_next = match;
        if (timeout) begin
            state_next = S_UNLOCK;
            match_next = '0;
        end else if (vs_rise) begin
            case (state)
                S_UNLOCK: begin
                    state_next = S_ACQUIRE;
                    match_next = '0;
                end
                S_ACQUIRE: begin
                    if (same) begin
                        match_next = match_inc;
                        if (match_inc >= LOCK_N)
                            state_next = S_LOCK;
                    end else begin
                        match_next = '0;
                    end
                end
                S_LOCK: begin
                    if (!same) begin
                        state_next = S_ACQUIRE;
                        match_next = '0;
                    end
                end
                default: begin
                    state_next = S_UNLOCK;
                    match_next = '0;
                end
            endcase
        end
    end

    always_comb begin
        locked = (state == S_LOCK);
    end

endmodule

// File: tb/tb_video_timing_detect.sv
// Directed bench for video_timing_detect using scaled-down rasters (16-sample lines)
// so full frames, lock acquisition, timeout and reset recovery fit in a short run.
`timescale 1ns/1ps
module tb_video_timing_detect;
    localparam int H_TOT   = 16;
    localparam int H_ACT   = 10;
    localparam int H_SYNC  = 2;
    localparam int TIMEOUT = 2048;

    logic        clk = 1'b0;
    logic        reset, ce_pix, hblank, hsync, vblank, vsync;
    logic [7:0]  video;
    logic [9:0]  x, y, h_total, v_total, h_active, v_active;
    logic        pixel_valid, frame_start, locked, pal_detect;
    logic [15:0] frame_sum;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   fs_cnt  = 0;
    int   phase   = 0;
    logic lk_pre, lk_post, fs_post, fs_a;

    video_timing_detect #(.LOCK_FRAMES(2), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .ce_pix(ce_pix),
        .hblank(hblank), .hsync(hsync), .vblank(vblank), .vsync(vsync), .video(video),
        .x(x), .y(y), .h_total(h_total), .v_total(v_total),
        .h_active(h_active), .v_active(v_active),
        .pixel_valid(pixel_valid), .frame_start(frame_start), .locked(locked),
        .pal_detect(pal_detect), .frame_sum(frame_sum)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (frame_start) fs_cnt++;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic drive_sample(input logic hs, input logic hb, input logic vs, input logic vb,
                                input logic [7:0] vid, input bit gap);
        hsync = hs; hblank = hb; vsync = vs; vblank = vb; video = vid; ce_pix = 1'b1;
        @(posedge clk); #1;
        fs_a = frame_start;
        if (gap) begin
            ce_pix = 1'b0;
            @(posedge clk); #1;
        end
    endtask

    task automatic drive_line(input int l, input int vt, input int va, input logic [7:0] vid,
                              input bit gap, input int s_from, input int s_to);
        for (int s = s_from; s <= s_to; s++) begin
            if (l == vt - 1 && s == 0) lk_pre = locked;
            drive_sample(s < H_SYNC, s >= H_ACT, l == vt - 1, l >= va, vid, gap);
            if (l == vt - 1 && s == 0) begin
                lk_post = locked;
                fs_post = fs_a;
            end
            if (phase == 1 && l == 5 && s == H_ACT - 1) begin
                check_eq("x_last_active", x, H_ACT - 1);
                check_eq("y_line5", y, 5);
                check_eq("pixel_valid_active", pixel_valid, 1);
            end
            if (phase == 1 && l == 5 && s == H_ACT)
                check_eq("pixel_valid_blank", pixel_valid, 0);
            if (phase == 2 && l == 0 && s == 0)
                check_eq("h_total_saturated", h_total, 1023);
        end
    endtask

    task automatic drive_frame(input int vt, input int va, input logic [7:0] vid, input bit gap);
        for (int l = 0; l < vt; l++)
            drive_line(l, vt, va, vid, gap, 0, H_TOT - 1);
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_x"}, x, 0);
        check_eq({tag, "_y"}, y, 0);
        check_eq({tag, "_h_total"}, h_total, 0);
        check_eq({tag, "_v_total"}, v_total, 0);
        check_eq({tag, "_h_active"}, h_active, 0);
        check_eq({tag, "_v_active"}, v_active, 0);
        check_eq({tag, "_pixel_valid"}, pixel_valid, 0);
        check_eq({tag, "_frame_start"}, frame_start, 0);
        check_eq({tag, "_locked"}, locked, 0);
        check_eq({tag, "_pal"}, pal_detect, 0);
        check_eq({tag, "_frame_sum"}, frame_sum, 0);
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; ce_pix = 1'b0; hblank = 1'b0; hsync = 1'b0;
        vblank = 1'b0; vsync = 1'b0; video = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        reset = 1'b0;

        // PAL-like raster: 312 lines, 301 active, full-scale video
        phase = 1;
        drive_frame(312, 301, 8'hFF, 0);
        phase = 0;
        check_eq("pal_h_total", h_total, 16);
        check_eq("pal_h_active", h_active, 10);
        check_eq("pal_v_total", v_total, 312);
        check_eq("pal_v_active", v_active, 301);
        check_eq("pal_detect_on", pal_detect, 1);
        check_eq("pal_frame_sum_ff", frame_sum, 16'hB63E);
        check_eq("pal_f1_locked", lk_post, 0);
        check_eq("pal_f1_frame_start", fs_post, 1);
        drive_frame(312, 301, 8'hFF, 0);
        check_eq("pal_f2_locked", lk_post, 0);
        drive_frame(312, 301, 8'hFF, 0);
        check_eq("pal_f3_pre_edge", lk_pre, 0);
        check_eq("pal_f3_locked", lk_post, 1);
        check_eq("pal_f3_frame_sum", frame_sum, 16'hB63E);
        drive_frame(312, 301, 8'h00, 0);
        check_eq("pal_f4_frame_sum_zero", frame_sum, 0);
        check_eq("pal_f4_locked", lk_post, 1);

        // NTSC-like raster: relock, then one 263-line frame
        drive_frame(262, 240, 8'h01, 0);
        check_eq("ntsc_a_pre_edge", lk_pre, 1);
        check_eq("ntsc_a_unlocked", lk_post, 0);
        check_eq("ntsc_v_total", v_total, 262);
        check_eq("ntsc_v_active", v_active, 240);
        check_eq("ntsc_pal_off", pal_detect, 0);
        check_eq("ntsc_frame_sum", frame_sum, 2400);
        drive_frame(262, 240, 8'h01, 0);
        check_eq("ntsc_b_locked", lk_post, 0);
        drive_frame(262, 240, 8'h01, 0);
        check_eq("ntsc_c_locked", lk_post, 1);
        drive_frame(263, 240, 8'h01, 0);
        check_eq("odd_pre_edge", lk_pre, 1);
        check_eq("odd_unlocked", lk_post, 0);
        check_eq("odd_v_total", v_total, 263);
        drive_frame(262, 240, 8'h01, 0);
        check_eq("re1_locked", lk_post, 0);
        drive_frame(262, 240, 8'h01, 0);
        check_eq("re2_locked", lk_post, 0);
        drive_frame(262, 240, 8'h01, 0);
        check_eq("re3_locked", lk_post, 1);
        check_eq("re3_v_total", v_total, 262);

        // hsync held low with ce toggling; 15 samples already elapsed since the last edge
        for (int i = 0; i < TIMEOUT - H_TOT; i++)
            drive_sample(1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 1);
        check_eq("timeout_minus1_locked", locked, 1);
        drive_sample(1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 1);
        check_eq("timeout_locked", locked, 0);
        check_eq("timeout_h_total_held", h_total, 16);
        check_eq("timeout_v_total_held", v_total, 262);
        check_eq("timeout_v_active_held", v_active, 240);

        // Small frames with ce_pix toggling every other clk
        phase = 2;
        drive_frame(12, 9, 8'h11, 1);
        phase = 0;
        check_eq("gap_h_total", h_total, 16);
        check_eq("gap_h_active", h_active, 10);
        check_eq("gap_v_total", v_total, 12);
        check_eq("gap_v_active", v_active, 9);
        check_eq("gap_frame_sum", frame_sum, 1530);
        check_eq("gap_f1_locked", lk_post, 0);
        drive_frame(12, 9, 8'h11, 1);
        check_eq("gap_f2_locked", lk_post, 0);
        drive_frame(12, 9, 8'h11, 1);
        check_eq("gap_f3_locked", lk_post, 1);

        // Reset mid-line while locked
        drive_line(0, 12, 9, 8'h11, 0, 0, 4);
        check_eq("pre_reset_locked", locked, 1);
        reset = 1'b1;
        @(posedge clk); #1;
        check_all_zero("midreset");
        reset = 1'b0;
        drive_line(0, 12, 9, 8'h11, 0, 5, H_TOT - 1);
        drive_line(1, 12, 9, 8'h11, 0, 0, 0);
        check_eq("after_reset_first_edge", h_total, 0);
        drive_line(1, 12, 9, 8'h11, 0, 1, H_TOT - 1);
        check_eq("after_reset_h_active", h_active, 10);
        drive_line(2, 12, 9, 8'h11, 0, 0, 0);
        check_eq("after_reset_second_edge", h_total, 16);

        check_eq("frame_start_pulses", fs_cnt, 14);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
